// File: rtl/i2c_cfg_pkg.sv
// Shared types and the default oscillator register table for the power-up
// I2C configuration sequencer.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_PWR,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_GAP,
    ST_SETTLE,
    ST_DONE,
    ST_FAIL
  } cfg_state_e;

  localparam int NUM_REGS_DEF = 11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // {reg, data} per table index; replace per board.
  function automatic logic [15:0] cfg_table(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'h8400;
      4'd1:    return 16'h0033;
      4'd2:    return 16'h05E4;
      4'd3:    return 16'h06D1;
      4'd4:    return 16'h07DF;
      4'd5:    return 16'h0896;
      4'd6:    return 16'h0908;
      4'd7:    return 16'h0A1E;
      4'd8:    return 16'h0B00;
      4'd9:    return 16'h8401;
      4'd10:   return 16'h8404;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Combinational table lookup: index -> {register, data}.
module i2c_config_rom
  import i2c_cfg_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [7:0] reg_o,
  output logic [7:0] data_o
);

  logic [15:0] entry;

  assign entry  = cfg_table(idx_i);
  assign reg_o  = entry[15:8];
  assign data_o = entry[7:0];

endmodule

// File: rtl/i2c_config_sequencer.sv
// Power-up register programming sequencer: walks the config table over a
// byte-write I2C engine with retry, then holds a settle delay before CFG_DONE.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int         NUM_REGS     = NUM_REGS_DEF,
  parameter logic [6:0] SLAVE_ADDR   = 7'h55,
  parameter int         PWRUP_DELAY  = 91000000,
  parameter int         SETTLE_DELAY = 151000000,
  parameter int         MAX_RETRY    = 3,
  parameter int         RETRY_GAP    = 4000,
  parameter int         RSP_TIMEOUT  = 20000
) (
  input  logic       CLOCK_IN,
  input  logic       RESET,
  input  logic       RESTART,
  output logic       CMD_VALID,
  input  logic       CMD_READY,
  output logic [6:0] CMD_SLAVE,
  output logic [7:0] CMD_REG,
  output logic [7:0] CMD_DATA,
  input  logic       RSP_VALID,
  input  logic       RSP_NACK,
  output logic       CFG_BUSY,
  output logic       CFG_DONE,
  output logic       CFG_FAIL,
  output logic [3:0] CFG_INDEX
);

  // Counter must hold every delay it serves, including timeout and gap.
  localparam int MAX_DLY = max_int(max_int(PWRUP_DELAY, SETTLE_DELAY),
                                   max_int(RETRY_GAP, RSP_TIMEOUT));
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_DELAY - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_DELAY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RETRY_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  cfg_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      state_q <= ST_WAIT_PWR;
      idx_q   <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_WAIT_PWR: begin
        if (cnt_q >= PWR_LAST) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      ST_ISSUE: begin
        if (CMD_READY) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        // A response landing on the timeout cycle takes precedence.
        if (RSP_VALID && !RSP_NACK) begin
          retry_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_SETTLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_ISSUE;
          end
        end else if (RSP_VALID || (cnt_q >= TO_LAST)) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q >= GAP_LAST) state_d = ST_ISSUE;
      end
      ST_SETTLE: begin
        if (cnt_q >= SET_LAST) state_d = ST_DONE;
      end
      ST_DONE, ST_FAIL: begin
        if (RESTART) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      default: state_d = ST_WAIT_PWR;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_inc;
  end

  i2c_config_rom u_rom (
    .idx_i  (idx_q),
    .reg_o  (CMD_REG),
    .data_o (CMD_DATA)
  );

  assign CMD_VALID = (state_q == ST_ISSUE);
  assign CMD_SLAVE = SLAVE_ADDR;
  assign CFG_BUSY  = (state_q != ST_DONE) && (state_q != ST_FAIL);
  assign CFG_DONE  = (state_q == ST_DONE);
  assign CFG_FAIL  = (state_q == ST_FAIL);
  assign CFG_INDEX = idx_q;

endmodule
